lsu_mmio: RTL and testbench
===========================

Name: lsu_mmio

Overview:
Parametrised load-store unit for the single-cycle/pipelined RV32I core.
- Decodes data addresses into data memory (DMEM), output peripherals (LEDR, LEDG, HEX, LCD) and input peripherals (switches).
- Supports all RV32I access sizes: byte, halfword and word, with sign or zero extension on loads.
- Fixed 1-cycle load latency with a valid strobe; misaligned accesses are detected and suppressed.
- Sits between the core's execute/memory stage and the board I/O.

Parameters:
DMEM_AW, 11, DMEM byte-address width (2^DMEM_AW bytes, word-organised)
NUM_HEX, 8, number of 7-segment digits driven (1..8)
LEDR_W, 17, red LED count
LEDG_W, 8, green LED count
SW_W, 18, switch count

Ports:
i_clk  in  1  clock (posedge)
i_rst_n  in  1  asynchronous active-low reset
i_req  in  1  access request this cycle
i_wren  in  1  1 = store, 0 = load (qualified by i_req)
i_funct3  in  3  RV32I size/sign: 000 b, 001 h, 010 w, 100 bu, 101 hu
i_lsu_addr  in  32  byte address
i_st_data  in  32  store data, LSB-justified
i_io_sw  in  SW_W  asynchronous switch inputs
o_ld_data  out  32  aligned, extended load data
o_ld_valid  out  1  load data valid, 1 cycle after load request
o_misalign  out  1  registered pulse: the previous-cycle request was misaligned
o_io_ledr  out  LEDR_W  red LEDs
o_io_ledg  out  LEDG_W  green LEDs
o_io_hex  out  7*NUM_HEX  digit k at bits [7k+6:7k]
o_io_lcd  out  32  LCD control/data word

Behaviour:
- Reset, asynchronous active-low: every output register, peripheral register, synchroniser flop and response flop is 0. DMEM contents are not reset.
- Address map uses a full compare of addr[31:12] (DMEM: addr[31:DMEM_AW] == 0):
  - DMEM 0x0000_0000 .. 2^DMEM_AW-1
  - LEDR 0x1000_0xxx
  - LEDG 0x1000_1xxx
  - HEX0-3 0x1000_2xxx
  - HEX4-7 0x1000_3xxx
  - LCD 0x1000_4xxx
  - SW 0x1001_0xxx
- Within a peripheral page, only the word at offset 0 is used; addr[11:2] is ignored.
- Unmapped address: store ignored; load returns 0 with o_ld_valid = 1.
- Alignment rules:
  - h/hu require addr[0] = 0.
  - w requires addr[1:0] = 0.
  - Misaligned request: no write, o_misalign = 1 next cycle, load returns 0 with valid.
  - Illegal funct3 (011, 110, 111) is treated as misaligned.
- Store byte mask:
  - sb: one lane selected by addr[1:0].
  - sh: lanes 1:0 or 3:2 selected by addr[1].
  - sw: 1111.
  - Data is replicated into the selected lanes.
  - Peripheral registers honour the byte mask, so a partial write updates only the selected bytes.
- Stores commit at the posedge of the request cycle. Peripheral outputs change in the same edge.
- Loads:
  - Request captured at posedge t.
  - o_ld_valid = 1 and o_ld_data valid during cycle t+1.
  - Back-to-back requests are allowed every cycle; the response pipeline is one deep.
  - Load data is shifted by addr[1:0] and then sign- or zero-extended per funct3.
- Read-after-write: a load issued the cycle after a store to the same DMEM word returns the new data.
- Peripheral readback:
  - LEDR, LEDG, HEX and LCD loads return the stored register value, zero-padded.
  - SW loads return the synchronised switches, zero-extended.
- i_io_sw passes through a 2-flop synchroniser. Load-visible latency from a switch change is ≤ 3 cycles.
- HEX registers:
  - Digit k = HEX register (k/4), byte (k%4), bits [6:0].
  - Bit 7 of each byte is stored but not driven.
  - A register whose digits are all ≥ NUM_HEX reads 0 and ignores writes.
- i_req = 0: no state change except the synchroniser; o_ld_valid = 0 and o_misalign = 0.
- Reset asserted mid-load clears o_ld_valid. No response is emitted after reset is released.

Decomposition:
- Shared package package_param holds:
  - funct3 constants (F3_LB..F3_LHU)
  - address base constants (DMEM_BASE, LEDR_BASE, LEDG_BASE, HEX03_BASE, HEX47_BASE, LCD_BASE, SW_BASE)
  - typedef enum region_e {REG_DMEM, REG_LEDR, REG_LEDG, REG_HEX03, REG_HEX47, REG_LCD, REG_SW, REG_NONE}
- One sub-module, lsu_dmem:
  - word-wide, 4-lane byte-enable synchronous-write RAM with registered synchronous read
  - depth 2^(DMEM_AW-2)
  - write-first on a same-address collision

Test Plan:
- sw 0xDEADBEEF @0x10, then lb @0x13 -> o_ld_data = 0xFFFFFFDE; lbu @0x13 -> 0x000000DE; lh @0x12 -> 0xFFFFDEAD; lhu @0x10 -> 0x0000BEEF; each with o_ld_valid one cycle after request.
- sw 0x11223344 @0x20, then sb 0xAA @0x21, then lw @0x20 next cycle -> 0x1122AA44, verifying read-after-write.
- sw 0x0001FFFF @0x1000_0000 -> o_io_ledr = 0x1FFFF the cycle after; sh 0x0000 @0x1000_0002 -> LEDR unchanged in bits [15:0], 0x0FFFF; lw readback = 0x0000FFFF.
- sw 0x7F063F5B @0x1000_2000 -> hex0 = 0x5B, hex1 = 0x3F, hex2 = 0x06, hex3 = 0x7F; NUM_HEX = 4 build: store to 0x1000_3000 ignored, readback 0.
- lw @0x0000_0002 and sh @0x0000_0001 -> o_misalign = 1 next cycle, DMEM word unchanged, load data 0; lw @0x2000_0000 (unmapped) -> 0 with valid, o_misalign = 0.
- i_io_sw = 0x2A5A5; lw @0x1001_0000 issued 1, 2 and 3 cycles later -> 0x2A5A5 seen by the third cycle; assert i_rst_n low during a pending load -> o_ld_valid = 0, all outputs 0.

Source files
------------

// File: rtl/package_param.sv
// Shared constants, types and small helpers for the load-store unit and its DMEM.
package package_param;

  localparam int unsigned XLEN = 32;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [31:0] DMEM_BASE  = 32'h0000_0000;
  localparam logic [31:0] LEDR_BASE  = 32'h1000_0000;
  localparam logic [31:0] LEDG_BASE  = 32'h1000_1000;
  localparam logic [31:0] HEX03_BASE = 32'h1000_2000;
  localparam logic [31:0] HEX47_BASE = 32'h1000_3000;
  localparam logic [31:0] LCD_BASE   = 32'h1000_4000;
  localparam logic [31:0] SW_BASE    = 32'h1001_0000;

  typedef enum logic [2:0] {
    REG_DMEM, REG_LEDR, REG_LEDG, REG_HEX03, REG_HEX47, REG_LCD, REG_SW, REG_NONE
  } region_e;

  // Load response captured at the request edge and consumed one cycle later.
  typedef struct packed {
    logic       valid;
    logic       err;
    region_e    region;
    logic [2:0] funct3;
    logic [1:0] off;
  } ld_rsp_t;

  // Illegal funct3 encodings are folded into the misaligned case.
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      F3_LB, F3_LBU: misaligned = 1'b0;
      F3_LH, F3_LHU: misaligned = off[0];
      F3_LW:         misaligned = (off != 2'b00);
      default:       misaligned = 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   store_be = 4'(4'b0001 << off);
      2'b01:   store_be = off[1] ? 4'b1100 : 4'b0011;
      default: store_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] d);
    case (f3[1:0])
      2'b00:   store_data = {4{d[7:0]}};
      2'b01:   store_data = {2{d[15:0]}};
      default: store_data = d;
    endcase
  endfunction

  function automatic logic [31:0] apply_be(input logic [31:0] old_w,
                                           input logic [31:0] new_w,
                                           input logic [3:0]  be);
    for (int unsigned i = 0; i < 4; i++)
      apply_be[8*i +: 8] = be[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] raw,
                                              input logic [2:0]  f3,
                                              input logic [1:0]  off);
    logic [31:0] sh;
    sh = raw >> {off, 3'b000};
    case (f3)
      F3_LB:   load_extend = {{24{sh[7]}}, sh[7:0]};
      F3_LH:   load_extend = {{16{sh[15]}}, sh[15:0]};
      F3_LBU:  load_extend = {24'b0, sh[7:0]};
      F3_LHU:  load_extend = {16'b0, sh[15:0]};
      default: load_extend = sh;
    endcase
  endfunction

endpackage

// File: rtl/lsu_mmio_dmem.sv
// Word-organised data RAM: byte-enable synchronous write, registered write-first read.
module lsu_dmem
  import package_param::*;
#(
  parameter int unsigned AW = 9
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_we,
  input  logic          i_re,
  input  logic [3:0]    i_be,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [31:0] mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int unsigned i = 0; i < 4; i++)
        if (i_be[i]) mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
    end
  end

  // Same-address write in the read cycle forwards the new bytes.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_rdata <= '0;
    end else if (i_re) begin
      for (int unsigned i = 0; i < 4; i++)
        o_rdata[8*i +: 8] <= (i_we && i_be[i]) ? i_wdata[8*i +: 8] : mem[i_addr][8*i +: 8];
    end
  end

endmodule

// File: rtl/lsu_mmio.sv
// Load-store unit: decodes DMEM and board peripherals, sizes/aligns data, 1-cycle loads.
module lsu_mmio
  import package_param::*;
#(
  parameter int unsigned DMEM_AW = 11,
  parameter int unsigned NUM_HEX = 8,
  parameter int unsigned LEDR_W  = 17,
  parameter int unsigned LEDG_W  = 8,
  parameter int unsigned SW_W    = 18
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_req,
  input  logic                 i_wren,
  input  logic [2:0]           i_funct3,
  input  logic [31:0]          i_lsu_addr,
  input  logic [31:0]          i_st_data,
  input  logic [SW_W-1:0]      i_io_sw,
  output logic [31:0]          o_ld_data,
  output logic                 o_ld_valid,
  output logic                 o_misalign,
  output logic [LEDR_W-1:0]    o_io_ledr,
  output logic [LEDG_W-1:0]    o_io_ledg,
  output logic [7*NUM_HEX-1:0] o_io_hex,
  output logic [31:0]          o_io_lcd
);

  localparam int unsigned WORD_AW  = DMEM_AW - 2;
  localparam bit          HEX47_EN = (NUM_HEX > 32'd4);

  region_e     region;
  logic        mis;
  logic        ld_req;
  logic        st_en;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [31:0] pdata_c;
  logic [31:0] pdata_q;
  logic [31:0] ram_rdata;
  logic [31:0] hex03;
  logic [31:0] hex47;
  logic [SW_W-1:0] sw_s1;
  logic [SW_W-1:0] sw_s2;
  logic        misalign_q;
  ld_rsp_t     rsp;

  // Full-page address decode.
  always_comb begin
    region = REG_NONE;
    if (i_lsu_addr[31:DMEM_AW] == DMEM_BASE[31:DMEM_AW]) begin
      region = REG_DMEM;
    end else begin
      case (i_lsu_addr[31:12])
        LEDR_BASE[31:12]:  region = REG_LEDR;
        LEDG_BASE[31:12]:  region = REG_LEDG;
        HEX03_BASE[31:12]: region = REG_HEX03;
        HEX47_BASE[31:12]: region = REG_HEX47;
        LCD_BASE[31:12]:   region = REG_LCD;
        SW_BASE[31:12]:    region = REG_SW;
        default:           region = REG_NONE;
      endcase
    end
  end

  assign mis    = misaligned(i_funct3, i_lsu_addr[1:0]);
  assign ld_req = i_req && !i_wren;
  assign st_en  = i_req && i_wren && !mis;
  assign be     = store_be(i_funct3, i_lsu_addr[1:0]);
  assign wdata  = store_data(i_funct3, i_st_data);

  lsu_dmem #(.AW(WORD_AW)) u_dmem (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_we    (st_en && (region == REG_DMEM)),
    .i_re    (ld_req && !mis && (region == REG_DMEM)),
    .i_be    (be),
    .i_addr  (i_lsu_addr[DMEM_AW-1:2]),
    .i_wdata (wdata),
    .o_rdata (ram_rdata)
  );

  // Peripheral registers, byte-enable merged.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_io_ledr <= '0;
      o_io_ledg <= '0;
      o_io_lcd  <= '0;
      hex03     <= '0;
      hex47     <= '0;
    end else if (st_en) begin
      case (region)
        REG_LEDR:  o_io_ledr <= LEDR_W'(apply_be(32'(o_io_ledr), wdata, be));
        REG_LEDG:  o_io_ledg <= LEDG_W'(apply_be(32'(o_io_ledg), wdata, be));
        REG_HEX03: hex03     <= apply_be(hex03, wdata, be);
        REG_HEX47: if (HEX47_EN) hex47 <= apply_be(hex47, wdata, be);
        REG_LCD:   o_io_lcd  <= apply_be(o_io_lcd, wdata, be);
        default:   ;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sw_s1 <= '0;
      sw_s2 <= '0;
    end else begin
      sw_s1 <= i_io_sw;
      sw_s2 <= sw_s1;
    end
  end

  always_comb begin
    pdata_c = '0;
    case (region)
      REG_LEDR:  pdata_c = 32'(o_io_ledr);
      REG_LEDG:  pdata_c = 32'(o_io_ledg);
      REG_HEX03: pdata_c = hex03;
      REG_HEX47: pdata_c = HEX47_EN ? hex47 : 32'h0;
      REG_LCD:   pdata_c = o_io_lcd;
      REG_SW:    pdata_c = 32'(sw_s2);
      default:   pdata_c = '0;
    endcase
  end

  // One-deep load response pipeline.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rsp        <= '0;
      pdata_q    <= '0;
      misalign_q <= 1'b0;
    end else begin
      rsp.valid  <= ld_req;
      misalign_q <= i_req && mis;
      if (ld_req) begin
        rsp.err    <= mis;
        rsp.region <= region;
        rsp.funct3 <= i_funct3;
        rsp.off    <= i_lsu_addr[1:0];
        pdata_q    <= pdata_c;
      end
    end
  end

  always_comb begin
    o_ld_data = '0;
    if (rsp.valid && !rsp.err) begin
      o_ld_data = load_extend((rsp.region == REG_DMEM) ? ram_rdata : pdata_q,
                              rsp.funct3, rsp.off);
    end
  end

  assign o_ld_valid = rsp.valid;
  assign o_misalign = misalign_q;

  // Digit k is the low 7 bits of byte k across the two HEX registers.
  always_comb begin
    logic [63:0] hex_all;
    hex_all  = {hex47, hex03};
    o_io_hex = '0;
    for (int unsigned k = 0; k < NUM_HEX; k++)
      o_io_hex[7*k +: 7] = hex_all[8*k +: 7];
  end

endmodule

// File: tb/tb_lsu_mmio.sv
// Directed bench for lsu_mmio: DMEM sizes/extension, peripherals, alignment, sync, reset.
module tb_lsu_mmio;
  import package_param::*;

  logic        clk;
  logic        rst_n;
  logic        req;
  logic        wren;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] st_data;
  logic [17:0] sw;

  logic [31:0] ld_data,  ld_data4;
  logic        ld_valid, ld_valid4;
  logic        misalign, misalign4;
  logic [16:0] ledr,     ledr4;
  logic [7:0]  ledg,     ledg4;
  logic [55:0] hex;
  logic [27:0] hex4;
  logic [31:0] lcd,      lcd4;

  int checks   = 0;
  int failures = 0;

  lsu_mmio dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_wren(wren), .i_funct3(funct3),
    .i_lsu_addr(addr), .i_st_data(st_data), .i_io_sw(sw),
    .o_ld_data(ld_data), .o_ld_valid(ld_valid), .o_misalign(misalign),
    .o_io_ledr(ledr), .o_io_ledg(ledg), .o_io_hex(hex), .o_io_lcd(lcd)
  );

  lsu_mmio #(.NUM_HEX(4)) dut4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_wren(wren), .i_funct3(funct3),
    .i_lsu_addr(addr), .i_st_data(st_data), .i_io_sw(sw),
    .o_ld_data(ld_data4), .o_ld_valid(ld_valid4), .o_misalign(misalign4),
    .o_io_ledr(ledr4), .o_io_ledg(ledg4), .o_io_hex(hex4), .o_io_lcd(lcd4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // Present one request at a negedge; returns at the next negedge (response cycle).
  task automatic op(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                    input logic [31:0] d);
    req = 1'b1; wren = wr; funct3 = f3; addr = a; st_data = d;
    @(negedge clk);
  endtask

  task automatic idle();
    req = 1'b0; wren = 1'b0; funct3 = 3'b000; addr = '0; st_data = '0;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; req = 1'b0; wren = 1'b0; funct3 = '0; addr = '0; st_data = '0; sw = '0;
    repeat (2) @(negedge clk);
    check("rst_valid", 32'(ld_valid), 32'h0);
    check("rst_misalign", 32'(misalign), 32'h0);
    check("rst_ledr", 32'(ledr), 32'h0);
    check("rst_hex", hex[31:0], 32'h0);
    check("rst_lcd", lcd, 32'h0);
    rst_n = 1'b1;
    idle();

    // Load sizes and extension
    op(1'b1, F3_LW, 32'h10, 32'hDEAD_BEEF);
    check("sw_no_valid", 32'(ld_valid), 32'h0);
    op(1'b0, F3_LB, 32'h13, 32'h0);
    check("lb_valid", 32'(ld_valid), 32'h1);
    check("lb", ld_data, 32'hFFFF_FFDE);
    op(1'b0, F3_LBU, 32'h13, 32'h0);
    check("lbu", ld_data, 32'h0000_00DE);
    op(1'b0, F3_LH, 32'h12, 32'h0);
    check("lh", ld_data, 32'hFFFF_DEAD);
    op(1'b0, F3_LHU, 32'h10, 32'h0);
    check("lhu", ld_data, 32'h0000_BEEF);
    op(1'b0, F3_LB, 32'h10, 32'h0);
    check("lb_neg_low", ld_data, 32'hFFFF_FFEF);
    idle();
    check("idle_valid", 32'(ld_valid), 32'h0);

    // Read-after-write with a byte merge
    op(1'b1, F3_LW, 32'h20, 32'h1122_3344);
    op(1'b1, F3_LB, 32'h21, 32'h0000_00AA);
    op(1'b0, F3_LW, 32'h20, 32'h0);
    check("raw_lw", ld_data, 32'h1122_AA44);
    idle();

    // LEDR / LEDG with byte masks
    op(1'b1, F3_LW, 32'h1000_0000, 32'h0001_FFFF);
    check("ledr_sw", 32'(ledr), 32'h0001_FFFF);
    op(1'b1, F3_LH, 32'h1000_0002, 32'h0000_0000);
    check("ledr_sh", 32'(ledr), 32'h0000_FFFF);
    op(1'b0, F3_LW, 32'h1000_0000, 32'h0);
    check("ledr_rd", ld_data, 32'h0000_FFFF);
    op(1'b1, F3_LB, 32'h1000_1003, 32'h0000_005A);
    check("ledg_hi_lane", 32'(ledg), 32'h0);
    op(1'b1, F3_LB, 32'h1000_1000, 32'h0000_00C3);
    check("ledg_sb", 32'(ledg), 32'h0000_00C3);

    // HEX digits and NUM_HEX=4 build
    op(1'b1, F3_LW, 32'h1000_2000, 32'h7F06_3F5B);
    check("hex0", 32'(hex[6:0]), 32'h5B);
    check("hex1", 32'(hex[13:7]), 32'h3F);
    check("hex2", 32'(hex[20:14]), 32'h06);
    check("hex3", 32'(hex[27:21]), 32'h7F);
    check("hex3_n4", 32'(hex4[27:21]), 32'h7F);
    op(1'b1, F3_LW, 32'h1000_3000, 32'h1234_5678);
    check("hex4", 32'(hex[34:28]), 32'h78);
    check("hex7", 32'(hex[55:49]), 32'h12);
    check("hex0_n4_kept", 32'(hex4[6:0]), 32'h5B);
    op(1'b0, F3_LW, 32'h1000_3000, 32'h0);
    check("hex47_rd", ld_data, 32'h1234_5678);
    check("hex47_rd_n4", ld_data4, 32'h0);
    op(1'b0, F3_LW, 32'h1000_2000, 32'h0);
    check("hex03_rd", ld_data, 32'h7F06_3F5B);

    // LCD and page-offset aliasing
    op(1'b1, F3_LW, 32'h1000_4000, 32'hCAFE_F00D);
    check("lcd", lcd, 32'hCAFE_F00D);
    op(1'b0, F3_LW, 32'h1000_4ABC, 32'h0);
    check("lcd_alias_rd", ld_data, 32'hCAFE_F00D);
    idle();

    // Misalignment, illegal funct3, unmapped
    op(1'b1, F3_LW, 32'h0, 32'h5566_7788);
    op(1'b0, F3_LW, 32'h2, 32'h0);
    check("mis_lw_valid", 32'(ld_valid), 32'h1);
    check("mis_lw_data", ld_data, 32'h0);
    check("mis_lw_flag", 32'(misalign), 32'h1);
    op(1'b1, F3_LH, 32'h1, 32'h0000_9999);
    check("mis_sh_flag", 32'(misalign), 32'h1);
    check("mis_sh_valid", 32'(ld_valid), 32'h0);
    op(1'b0, F3_LW, 32'h0, 32'h0);
    check("mis_word_kept", ld_data, 32'h5566_7788);
    check("aligned_flag", 32'(misalign), 32'h0);
    op(1'b0, 3'b011, 32'h0, 32'h0);
    check("illegal_f3_flag", 32'(misalign), 32'h1);
    check("illegal_f3_data", ld_data, 32'h0);
    op(1'b0, F3_LW, 32'h2000_0000, 32'h0);
    check("unmapped_valid", 32'(ld_valid), 32'h1);
    check("unmapped_data", ld_data, 32'h0);
    check("unmapped_flag", 32'(misalign), 32'h0);
    idle();
    check("idle_flag", 32'(misalign), 32'h0);

    // Switch synchroniser: third back-to-back load must see the new value
    sw = 18'h2A5A5;
    op(1'b0, F3_LW, 32'h1001_0000, 32'h0);
    op(1'b0, F3_LW, 32'h1001_0000, 32'h0);
    op(1'b0, F3_LW, 32'h1001_0000, 32'h0);
    check("sw_sync", ld_data, 32'h0002_A5A5);
    idle();

    // Reset during a pending load
    req = 1'b1; wren = 1'b0; funct3 = F3_LW; addr = 32'h10;
    @(posedge clk);
    #1;
    check("pend_valid", 32'(ld_valid), 32'h1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_valid", 32'(ld_valid), 32'h0);
    check("rst_mid_data", ld_data, 32'h0);
    check("rst_mid_ledr", 32'(ledr), 32'h0);
    check("rst_mid_lcd", lcd, 32'h0);
    check("rst_mid_hex", hex[31:0], 32'h0);
    req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_valid", 32'(ld_valid), 32'h0);
    op(1'b0, F3_LW, 32'h10, 32'h0);
    check("dmem_survives_rst", ld_data, 32'hDEAD_BEEF);
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
